// File: rtl/datapath_sequencer.sv
// datapath_sequencer: issues a loadable program of (instr, operand) pairs to an 8-bit ALU datapath
//   clk, rst_n (async, active-low)
//   prog_we/prog_addr/prog_data : program store write port, accepted only in IDLE
//   start/length                : run request, length 1..DEPTH
//   dp_instr/dp_data_in/dp_valid: issue port to the datapath, dp_data_out: its result
//   result, step_idx, busy, done, err : status
module datapath_sequencer #(
  parameter int DEPTH = 16,
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        start,
  input  logic [4:0]  length,
  output logic [7:0]  dp_instr,
  output logic [7:0]  dp_data_in,
  output logic        dp_valid,
  input  logic [7:0]  dp_data_out,
  output logic [7:0]  result,
  output logic [3:0]  step_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] mem [DEPTH];
  logic [15:0] cur;
  logic [2:0]  cnt;
  logic [4:0]  len;
  logic        len_ok, accept, last_wait, last_step;
  assign len_ok    = (length != 5'd0) && (length <= 5'(DEPTH));
  assign accept    = (state == IDLE) && start && len_ok;
  assign last_wait = cnt == 3'd1;
  assign last_step = ({1'b0, step_idx} + 5'd1) == len;
  assign cur       = mem[step_idx];
  assign dp_valid   = state == ISSUE;
  assign dp_instr   = dp_valid ? cur[15:8] : 8'd0;
  assign dp_data_in = dp_valid ? cur[7:0] : 8'd0;
  assign busy       = (state == ISSUE) || (state == WAIT);
  assign done       = state == DONE;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = last_wait ? (last_step ? DONE : ISSUE) : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      len      <= '0;
      step_idx <= '0;
      result   <= '0;
      err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // a write outside IDLE and a bad-length start in IDLE are both rejected commands
      err <= (prog_we && (state != IDLE)) || ((state == IDLE) && start && !len_ok);
      if (prog_we && (state == IDLE)) mem[prog_addr] <= prog_data;
      if (accept) begin
        len      <= length;
        step_idx <= '0;
      end
      if (state == ISSUE) cnt <= 3'(LAT);
      if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        if (last_wait) begin
          result <= dp_data_out;
          if (!last_step) step_idx <= step_idx + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed scoreboard bench for datapath_sequencer
module tb_datapath_sequencer;
  localparam int LAT = 1;
  logic        clk = 1'b0, rst_n = 1'b0, prog_we = 1'b0, start = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [4:0]  length = '0;
  logic [7:0]  dp_instr, dp_data_in, result;
  logic [7:0]  dp_data_out = '0;
  logic        dp_valid, busy, done, err;
  logic [3:0]  step_idx;
  logic [15:0] mdl [16];
  logic [19:0] iq [$];
  logic [7:0]  rq [$];
  int n_cmp = 0, n_bad = 0, pend = 0, cyc = 0;

  datapath_sequencer #(.DEPTH(16), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .length(length), .dp_instr(dp_instr), .dp_data_in(dp_data_in),
    .dp_valid(dp_valid), .dp_data_out(dp_data_out), .result(result), .step_idx(step_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // datapath stand-in: returns operand+1 one edge after issue
  always @(posedge clk) if (dp_valid) dp_data_out <= dp_data_in + 8'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: issues and results are popped as the DUT produces them
  always @(negedge clk) begin
    if (!rst_n) begin
      iq.delete();
      rq.delete();
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          check("result_expected", 32'(rq.size() != 0), 1);
          if (rq.size() != 0) check("result", 32'(result), 32'(rq.pop_front()));
        end
      end
      if (dp_valid) begin
        check("issue_expected", 32'(iq.size() != 0), 1);
        if (iq.size() != 0) check("issue", {12'd0, step_idx, dp_instr, dp_data_in}, 32'(iq.pop_front()));
        pend = 1 + LAT;
      end
    end
  end

  task automatic expect_run(input int n);
    for (int i = 0; i < n; i++) begin
      iq.push_back({4'(i), mdl[i]});
      rq.push_back(mdl[i][7:0] + 8'd1);
    end
  endtask

  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = d; mdl[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic go(input int n);
    @(negedge clk);
    start = 1'b1; length = 5'(n);
    expect_run(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < maxc);
    check("done_seen", 32'(done), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    // reset values
    #2;
    check("rst_async", {busy, done, err, dp_valid, dp_instr, dp_data_in, result, step_idx}, 0);
    @(negedge clk);
    check("rst_hold", {busy, done, err, dp_valid, dp_instr, dp_data_in, result, step_idx}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    // entry 0 of the cleared store issues zeros
    go(1);
    wait_done(16, cyc);
    check("rst_run_len", cyc, 3);
    // basic run, entry 2 written on the same edge as start
    load(0, 16'h0005);
    load(1, 16'h4009);
    @(negedge clk);
    start = 1'b1; length = 5'd3;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 16'h8003; mdl[2] = 16'h8003;
    expect_run(3);
    @(posedge clk);
    #1 start = 1'b0; prog_we = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("basic_valid_c%0d", c), 32'(dp_valid), 32'((c % 2 == 1) && c <= 5));
      check($sformatf("basic_busy_c%0d", c), 32'(busy), 32'(c <= 6));
      check($sformatf("basic_done_c%0d", c), 32'(done), 32'(c == 7));
      check($sformatf("basic_err_c%0d", c), 32'(err), 0);
    end
    check("basic_final_result", 32'(result), 8'd4);
    check("basic_final_step", 32'(step_idx), 2);
    // length errors
    @(negedge clk);
    start = 1'b1; length = 5'd0;
    @(negedge clk);
    check("len0_err", 32'(err), 1);
    check("len0_busy", 32'(busy), 0);
    length = 5'd17;
    @(negedge clk);
    check("len17_err", 32'(err), 1);
    check("len17_busy", 32'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    check("lenerr_clear", {err, busy, dp_valid}, 0);
    check("lenerr_result", 32'(result), 8'd4);
    // write while busy is dropped
    go(2);
    @(negedge clk);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'hFFFF;
    @(negedge clk);
    prog_we = 1'b0;
    check("wrbusy_err", 32'(err), 1);
    wait_done(16, cyc);
    check("wrbusy_done_at", cyc, 2);
    check("wrbusy_err_gone", 32'(err), 0);
    // full depth with start held high
    for (int i = 0; i < 16; i++) load(i, 16'(i * 16'h1357 ^ 16'h0A5C));
    @(negedge clk);
    start = 1'b1; length = 5'd16;
    expect_run(16);
    expect_run(16);
    @(posedge clk);
    #1;
    wait_done(64, cyc);
    check("full_done_at", cyc, 33);
    check("full_step_final", 32'(step_idx), 15);
    @(negedge clk);
    check("full_idle_gap", {busy, dp_valid, err}, 0);
    @(negedge clk);
    check("full_rerun_issue", 32'(dp_valid), 1);
    start = 1'b0;
    wait_done(64, cyc);
    check("full_rerun_done_at", cyc, 32);
    // reset mid-run during step 1 WAIT
    go(3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_step1_issue", 32'(step_idx), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_clear", {busy, done, err, dp_valid, dp_instr, dp_data_in, result, step_idx}, 0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid_no_done_%0d", c), 32'(done), 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("mid_post_no_done", {done, busy}, 0);
    go(2);
    wait_done(16, cyc);
    check("mid_rerun_done_at", cyc, 5);
    @(negedge clk);
    @(negedge clk);
    check("sb_issue_drained", iq.size(), 0);
    check("sb_result_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
